load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage of the multi-cycle RV64I processor, sitting between EXECUTE and WRITE BACK. It accepts one load or store per handshake from execute, carrying the computed address, store data, funct3 and rd. It drives a 64-bit data-memory request/grant/response bus and returns sign- or zero-extended load data plus a register write enable to writeback. Misaligned and illegal-width accesses are reported as faults without touching memory.

## Interface
- XLEN, 64, datapath and address width; fixed at 64.
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and reset values immediately
- req_valid  in  1  execute presents an access
- req_ready  out  1  unit can accept; high only in IDLE
- req_is_store  in  1  1 = STORE opcode, 0 = LOAD opcode
- req_funct3  in  3  instruction funct3 (width/sign)
- req_addr  in  64  effective address rs1+imm
- req_wdata  in  64  rs2 value (stores)
- req_rd  in  5  destination register (loads)
- mem_req  out  1  bus request; held until mem_gnt
- mem_we  out  1  1 = write
- mem_addr  out  64  8-byte-aligned address {req_addr[63:3],3'b000}
- mem_wdata  out  64  lane-shifted store data
- mem_be  out  8  byte enables
- mem_gnt  in  1  bus accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  64  read data
- done_valid  out  1  one-cycle completion pulse
- done_we  out  1  write rd (load and rd≠0)
- done_rd  out  5  destination register
- done_data  out  64  extended load data; 0 for stores
- fault_valid  out  1  one-cycle fault pulse
- fault_store  out  1  1 = store fault, 0 = load fault
- fault_addr  out  64  offending req_addr

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: req_ready=1. On req_valid, latch all req_* fields, then check legality:
  - size = 1<<funct3[1:0].
  - Illegal if a load uses funct3=3'b111, or a store has funct3[2]=1.
  - Misaligned if req_addr & (size-1) ≠ 0.
  - Illegal or misaligned: the next cycle pulses fault_valid with fault_store and fault_addr, issues no mem_req, and stays in IDLE.
  - Legal: go to REQ.
- REQ: mem_req=1. mem_we, mem_addr, mem_wdata and mem_be are stable until mem_gnt.
  - mem_be = ((1<<size)-1) << addr[2:0].
  - mem_wdata = wdata << (8*addr[2:0]).
  - For loads, mem_wdata=0 and mem_be is computed the same way.
  - On mem_gnt: a store goes to IDLE with done_valid=1, done_we=0. A load goes to WAIT.
- WAIT: on mem_rvalid, extract lane = mem_rdata >> (8*addr[2:0]) and truncate to size.
  - funct3[2]=0: sign-extend; funct3[2]=1: zero-extend.
  - Go to IDLE with done_valid=1, done_data=result, done_rd=rd, done_we=(rd≠0).
- Ignored inputs: mem_gnt outside REQ; mem_rvalid outside WAIT, including stale responses after reset.
- At most one access is outstanding.

## Timing
- Reset values: req_ready=1, all other outputs 0, state IDLE. Reset mid-REQ drops mem_req asynchronously and no done is produced.
- done_* and fault_* are registered one-cycle pulses, asserted in the first IDLE cycle after completion. They are never asserted together.
- req_ready is high in that same cycle, so back-to-back accesses need no bubble.
- Latency, accept cycle = T:
  - mem_req is high from T+1.
  - Store with gnt at T+1+g: done at T+2+g.
  - Load with rvalid at cycle R (R ≥ gnt cycle+1): done at R+1.
  - Fault: fault_valid at T+1.
- mem_gnt and mem_rvalid in the same cycle as the request are not supported. rvalid is sampled only in WAIT.

## Test plan
- LW at 0x80001004, mem_rdata=0x8765432112345678, rd=5 -> mem_addr=0x80001000, mem_be=0xF0, done_data=0xFFFFFFFF87654321, done_we=1. The same access as LWU -> 0x0000000087654321.
- SH at 0x80002006, req_wdata=0x000000000000BEEF -> mem_we=1, mem_be=0xC0, mem_wdata=0xBEEF000000000000, done_valid one cycle after gnt, done_we=0.
- LD at 0x80000004 -> fault_valid=1, fault_store=0, fault_addr=0x80000004, mem_req never asserted. Load funct3=3'b111 at an aligned address -> same fault.
- mem_gnt delayed 3 cycles on SD at 0x80003000 -> mem_req, mem_addr, mem_wdata and mem_be=0xFF stay constant for 4 cycles. Spurious mem_rvalid pulses during REQ cause no done.
- LB at offset 7 with mem_rdata[63:56]=0x80, rd=0 -> done_data=0xFFFFFFFFFFFFFF80, done_we=0. LBU at the same address -> 0x80.
- Reset asserted in WAIT, then mem_rvalid after release -> outputs at reset values, no done_valid, and the next request is accepted normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-access stage of the multi-cycle RV64I core, between EXECUTE and
// WRITE BACK. It takes one load or store per handshake, runs it over a
// 64-bit request/grant/response data bus and returns extended load data
// with a register write enable. Misaligned or illegal-width accesses are
// reported as faults and never reach the bus.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid / req_ready      access handshake from execute
//   req_is_store, req_funct3   access kind, width and signedness
//   req_addr, req_wdata        effective address and store data
//   req_rd                     load destination register
//   mem_req/we/addr/wdata/be   data-memory request, held until mem_gnt
//   mem_gnt                    bus accepts the request
//   mem_rvalid, mem_rdata      load response
//   done_valid/we/rd/data      one-cycle completion pulse to writeback
//   fault_valid/store/addr     one-cycle fault pulse
module load_store_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            done_valid,
  output logic            done_we,
  output logic [4:0]      done_rd,
  output logic [XLEN-1:0] done_data,
  output logic            fault_valid,
  output logic            fault_store,
  output logic [XLEN-1:0] fault_addr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} stateT;

  stateT           state, nextState;
  logic            isStoreQ;
  logic [2:0]      funct3Q;
  logic [XLEN-1:0] addrQ;
  logic [XLEN-1:0] wdataQ;
  logic [4:0]      rdQ;

  logic            accept;
  logic [2:0]      sizeMask;
  logic            illegal;
  logic            reqFault;
  logic [7:0]      beBase;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] loadResult;

  assign accept = (state == IDLE) && req_valid;

  // Legality is judged on the incoming request so a fault can be
  // reported in the very next cycle without leaving IDLE.
  always_comb begin
    sizeMask = 3'd0;
    case (req_funct3[1:0])
      2'd0:    sizeMask = 3'd0;
      2'd1:    sizeMask = 3'd1;
      2'd2:    sizeMask = 3'd3;
      default: sizeMask = 3'd7;
    endcase
    illegal  = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);
    reqFault = illegal || ((req_addr[2:0] & sizeMask) != 3'd0);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic: one access outstanding at a time.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept && !reqFault) nextState = REQ;
      REQ:     if (mem_gnt) nextState = isStoreQ ? IDLE : WAIT;
      WAIT:    if (mem_rvalid) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Bus outputs come from the latched request, so they stay stable for
  // the whole REQ phase and read as zero everywhere else.
  always_comb begin
    beBase = 8'h00;
    case (funct3Q[1:0])
      2'd0:    beBase = 8'h01;
      2'd1:    beBase = 8'h03;
      2'd2:    beBase = 8'h0F;
      default: beBase = 8'hFF;
    endcase
    req_ready = (state == IDLE);
    mem_req   = (state == REQ);
    mem_we    = (state == REQ) && isStoreQ;
    mem_addr  = (state == REQ) ? {addrQ[XLEN-1:3], 3'b000} : '0;
    mem_be    = (state == REQ) ? (beBase << addrQ[2:0]) : 8'h00;
    mem_wdata = ((state == REQ) && isStoreQ) ? (wdataQ << {addrQ[2:0], 3'b000}) : '0;
  end

  // Load lane extraction: shift the addressed bytes down, then sign- or
  // zero-extend according to funct3[2].
  always_comb begin
    lane       = mem_rdata >> {addrQ[2:0], 3'b000};
    loadResult = lane;
    case (funct3Q[1:0])
      2'd0: loadResult = funct3Q[2] ? {{(XLEN-8){1'b0}}, lane[7:0]}
                                    : {{(XLEN-8){lane[7]}}, lane[7:0]};
      2'd1: loadResult = funct3Q[2] ? {{(XLEN-16){1'b0}}, lane[15:0]}
                                    : {{(XLEN-16){lane[15]}}, lane[15:0]};
      2'd2: loadResult = funct3Q[2] ? {{(XLEN-32){1'b0}}, lane[31:0]}
                                    : {{(XLEN-32){lane[31]}}, lane[31:0]};
      default: loadResult = lane;
    endcase
  end

  // Request capture on every accepted handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isStoreQ <= 1'b0;
      funct3Q  <= 3'd0;
      addrQ    <= '0;
      wdataQ   <= '0;
      rdQ      <= 5'd0;
    end else if (accept) begin
      isStoreQ <= req_is_store;
      funct3Q  <= req_funct3;
      addrQ    <= req_addr;
      wdataQ   <= req_wdata;
      rdQ      <= req_rd;
    end
  end

  // Completion and fault pulses: cleared every cycle unless an event
  // fires, and the three sources are mutually exclusive by state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_valid  <= 1'b0;
      done_we     <= 1'b0;
      done_rd     <= 5'd0;
      done_data   <= '0;
      fault_valid <= 1'b0;
      fault_store <= 1'b0;
      fault_addr  <= '0;
    end else begin
      done_valid  <= 1'b0;
      done_we     <= 1'b0;
      done_rd     <= 5'd0;
      done_data   <= '0;
      fault_valid <= 1'b0;
      fault_store <= 1'b0;
      fault_addr  <= '0;
      if (accept && reqFault) begin
        fault_valid <= 1'b1;
        fault_store <= req_is_store;
        fault_addr  <= req_addr;
      end else if ((state == REQ) && mem_gnt && isStoreQ) begin
        done_valid <= 1'b1;
      end else if ((state == WAIT) && mem_rvalid) begin
        done_valid <= 1'b1;
        done_we    <= (rdQ != 5'd0);
        done_rd    <= rdQ;
        done_data  <= loadResult;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Directed bench for load_store_unit. Stimulus pushes the expected
// completion or fault into a queue; a separate monitor pops and compares
// whenever the unit pulses done_valid or fault_valid.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        done_valid;
  logic        done_we;
  logic [4:0]  done_rd;
  logic [63:0] done_data;
  logic        fault_valid;
  logic        fault_store;
  logic [63:0] fault_addr;

  typedef struct {
    bit          isFault;
    bit          faultStore;
    logic [63:0] faultAddr;
    bit          we;
    logic [4:0]  rd;
    logic [63:0] data;
  } expT;

  expT expQ[$];
  int  total = 0;
  int  bad   = 0;

  load_store_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .done_valid(done_valid), .done_we(done_we), .done_rd(done_rd),
    .done_data(done_data), .fault_valid(fault_valid),
    .fault_store(fault_store), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: every done/fault pulse must match the oldest expectation.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (done_valid === 1'b1 || fault_valid === 1'b1) begin
        checkOutput("doneFaultExclusive", {63'b0, done_valid & fault_valid}, 64'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpectedPulse", {62'b0, done_valid, fault_valid}, 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("pulseKind", {63'b0, fault_valid}, {63'b0, e.isFault});
          if (e.isFault) begin
            checkOutput("faultStore", {63'b0, fault_store}, {63'b0, e.faultStore});
            checkOutput("faultAddr", fault_addr, e.faultAddr);
          end else begin
            checkOutput("doneWe", {63'b0, done_we}, {63'b0, e.we});
            checkOutput("doneRd", {59'b0, done_rd}, {59'b0, e.rd});
            checkOutput("doneData", done_data, e.data);
          end
        end
      end
    end
  end

  // Runs one access end to end, checking the bus side each cycle and
  // queueing the completion/fault the monitor should see.
  task automatic applyStimulus(input string name, input bit isStore, input logic [2:0] f3,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [4:0] rd, input logic [63:0] rdata,
                               input int gntDelay, input int rvalidDelay, input bit spurious,
                               input bit expFault, input logic [7:0] expBe,
                               input logic [63:0] expWdata, input logic [63:0] expData);
    expT e;
    logic [63:0] expAddr;
    expAddr      = {addr[63:3], 3'b000};
    e.isFault    = expFault;
    e.faultStore = isStore;
    e.faultAddr  = addr;
    e.we         = !isStore && (rd != 5'd0);
    e.rd         = isStore ? 5'd0 : rd;
    e.data       = isStore ? 64'd0 : expData;
    @(negedge clk);
    checkOutput({name, ".ready"}, {63'b0, req_ready}, 64'd1);
    req_valid    = 1'b1;
    req_is_store = isStore;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;
    if (expFault) expQ.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    if (expFault) begin
      checkOutput({name, ".noReq"}, {63'b0, mem_req}, 64'd0);
      @(negedge clk);
      checkOutput({name, ".noReqLater"}, {63'b0, mem_req}, 64'd0);
      return;
    end
    for (int i = 0; i <= gntDelay; i++) begin
      checkOutput({name, ".memReq"}, {63'b0, mem_req}, 64'd1);
      checkOutput({name, ".memWe"}, {63'b0, mem_we}, {63'b0, isStore});
      checkOutput({name, ".memAddr"}, mem_addr, expAddr);
      checkOutput({name, ".memBe"}, {56'b0, mem_be}, {56'b0, expBe});
      checkOutput({name, ".memWdata"}, mem_wdata, expWdata);
      if (i == gntDelay) begin
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b0;
        if (isStore) expQ.push_back(e);
      end else begin
        mem_rvalid = spurious;
      end
      @(negedge clk);
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (!isStore) begin
      repeat (rvalidDelay) begin
        checkOutput({name, ".waitNoReq"}, {63'b0, mem_req}, 64'd0);
        @(negedge clk);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      expQ.push_back(e);
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'd0;
    req_addr     = 64'd0;
    req_wdata    = 64'd0;
    req_rd       = 5'd0;
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = 64'd0;

    @(negedge clk);
    checkOutput("rst.ready", {63'b0, req_ready}, 64'd1);
    checkOutput("rst.memReq", {63'b0, mem_req}, 64'd0);
    checkOutput("rst.memBe", {56'b0, mem_be}, 64'd0);
    checkOutput("rst.done", {63'b0, done_valid}, 64'd0);
    checkOutput("rst.fault", {63'b0, fault_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("LW", 1'b0, 3'b010, 64'h80001004, 64'd0, 5'd5, 64'h8765432112345678,
                  0, 1, 1'b0, 1'b0, 8'hF0, 64'd0, 64'hFFFFFFFF87654321);
    applyStimulus("LWU", 1'b0, 3'b110, 64'h80001004, 64'd0, 5'd5, 64'h8765432112345678,
                  2, 0, 1'b0, 1'b0, 8'hF0, 64'd0, 64'h0000000087654321);
    applyStimulus("SH", 1'b1, 3'b001, 64'h80002006, 64'h000000000000BEEF, 5'd0, 64'd0,
                  1, 0, 1'b0, 1'b0, 8'hC0, 64'hBEEF000000000000, 64'd0);
    applyStimulus("LDmis", 1'b0, 3'b011, 64'h80000004, 64'd0, 5'd3, 64'd0,
                  0, 0, 1'b0, 1'b1, 8'h00, 64'd0, 64'd0);
    applyStimulus("L111", 1'b0, 3'b111, 64'h80000008, 64'd0, 5'd3, 64'd0,
                  0, 0, 1'b0, 1'b1, 8'h00, 64'd0, 64'd0);
    applyStimulus("S100", 1'b1, 3'b100, 64'h80000010, 64'd1, 5'd0, 64'd0,
                  0, 0, 1'b0, 1'b1, 8'h00, 64'd0, 64'd0);
    applyStimulus("SWmis", 1'b1, 3'b010, 64'h80000012, 64'd1, 5'd0, 64'd0,
                  0, 0, 1'b0, 1'b1, 8'h00, 64'd0, 64'd0);
    applyStimulus("SDslow", 1'b1, 3'b011, 64'h80003000, 64'h0123456789ABCDEF, 5'd0, 64'd0,
                  3, 0, 1'b1, 1'b0, 8'hFF, 64'h0123456789ABCDEF, 64'd0);
    applyStimulus("LB", 1'b0, 3'b000, 64'h80004007, 64'd0, 5'd0, 64'h8011223344556677,
                  0, 0, 1'b0, 1'b0, 8'h80, 64'd0, 64'hFFFFFFFFFFFFFF80);
    applyStimulus("LBU", 1'b0, 3'b100, 64'h80004007, 64'd0, 5'd9, 64'h8011223344556677,
                  0, 0, 1'b0, 1'b0, 8'h80, 64'd0, 64'h0000000000000080);
    applyStimulus("LHU", 1'b0, 3'b101, 64'h80004002, 64'd0, 5'd4, 64'h1122334455667788,
                  0, 0, 1'b0, 1'b0, 8'h0C, 64'd0, 64'h0000000000005566);

    // Reset while the request is on the bus must drop mem_req at once.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b011;
    req_addr = 64'h80005000; req_wdata = 64'h5555; req_rd = 5'd0;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rstReq.memReqBefore", {63'b0, mem_req}, 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstReq.memReqAsync", {63'b0, mem_req}, 64'd0);
    checkOutput("rstReq.ready", {63'b0, req_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // Reset while waiting for read data; a late response must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 64'h80006000; req_rd = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checkOutput("rstWait.inWait", {62'b0, req_ready, mem_req}, 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("rstWait.ready", {63'b0, req_ready}, 64'd1);
    checkOutput("rstWait.done", {63'b0, done_valid}, 64'd0);
    @(negedge clk);
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEADBEEFDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checkOutput("rstWait.staleNoDone", {63'b0, done_valid}, 64'd0);

    applyStimulus("LDafter", 1'b0, 3'b011, 64'h80007008, 64'd0, 5'd10, 64'h1122334455667788,
                  0, 0, 1'b0, 1'b0, 8'hFF, 64'd0, 64'h1122334455667788);

    repeat (3) @(negedge clk);
    checkOutput("pendingExpected", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
